mmio_uart_tx: RTL

//   Memory-mapped UART transmitter on the single-cycle core's data-store port.

---
 rtl/mmio_uart_tx.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: snoops core stores, queues bytes in a FIFO, sends them 8N1 on tx.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        tx,
  output logic        Busy
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
`ifdef MMIO_UART_PARITY_EN
  localparam logic ParityEn = 1'b1;
`else
  localparam logic ParityEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Address decode
  logic [31:0] offset;
  logic        txdataSel;
  logic        statusSel;
  logic        pushReq;
  logic        unusedWriteData;

  assign offset          = DataAdr - BASE_ADDR;
  assign Hit             = (offset < 32'd8);
  assign txdataSel       = (DataAdr == BASE_ADDR);
  assign statusSel       = (DataAdr == BASE_ADDR + 32'd4);
  assign pushReq         = MemWrite && txdataSel;
  assign unusedWriteData = ^WriteData[31:8];

  // Byte FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr_q;
  logic [PtrW-1:0] rdPtr_q;
  logic [CntW-1:0] count_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            overflow_q;

  state_e          state_q;
  state_e          state_d;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign push  = pushReq && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PtrW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Full is judged before any same-cycle pop, so a push at full is always dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (pushReq && full) begin
      overflow_q <= 1'b1;
    end else if (MemWrite && statusSel) begin
      overflow_q <= 1'b0;
    end
  end

  // Serialiser
  logic [BaudW-1:0] baud_q;
  logic [BaudW-1:0] baud_d;
  logic [2:0]       bitCnt_q;
  logic [2:0]       bitCnt_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             tx_q;
  logic             tx_d;
  logic             baudDone;
`ifdef MMIO_UART_PARITY_EN
  logic             parity_q;
  logic             parity_d;
`endif

  assign baudDone = (baud_q == BaudLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef MMIO_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx is registered from the current state, so the line lags the state by one cycle
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
`ifdef MMIO_UART_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d  = mem_q[rdPtr_q];
          baud_d   = '0;
          bitCnt_d = '0;
          state_d  = S_START;
`ifdef MMIO_UART_PARITY_EN
          parity_d = ^mem_q[rdPtr_q];
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baudDone) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baudDone) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bitCnt_q == 3'd7) begin
            bitCnt_d = '0;
`ifdef MMIO_UART_PARITY_EN
            state_d  = S_PARITY;
`else
            state_d  = S_STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (baudDone) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baudDone) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign Busy     = !empty || (state_q != S_IDLE);
  assign ReadData = statusSel ? {27'd0, ParityEn, overflow_q, Busy, empty, full} : 32'd0;

endmodule
